// File: rtl/puf_pkg.sv
// puf_pkg: shared types, width defaults and helpers for the arbiter-PUF CRP sequencer.
package puf_pkg;

    localparam int CH_W_DEF   = 8;
    localparam int RESP_W_DEF = 8;
    localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_EMIT
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// puf_vote_counter: per-bit synchroniser, vote counter, majority and unanimity check.
// Unanimity logic exists only when PUF_UNSTABLE_FLAG_EN is defined.
module puf_vote_counter
    import puf_pkg::*;
#(
    parameter int VOTES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic resp_i,
    input  logic sample_i,
    input  logic clear_i,
    output logic maj_o,
    output logic unstable_o
);

    localparam int CW = clog2(VOTES + 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= resp_i;
            s2_q <= s1_q;
            if (clear_i)
                cnt_q <= '0;
            else if (sample_i && s2_q)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign maj_o = cnt_q > CW'(VOTES / 2);

`ifdef PUF_UNSTABLE_FLAG_EN
    assign unstable_o = (cnt_q != '0) && (cnt_q != CW'(VOTES));
`else
    assign unstable_o = 1'b0;
`endif

endmodule

// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: LFSR challenge generator, launch sequencer and majority-voted CRP emitter.
// out_unstable is driven only when PUF_UNSTABLE_FLAG_EN is defined; otherwise it reads 0.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int              CH_W      = CH_W_DEF,
    parameter int              RESP_W    = RESP_W_DEF,
    parameter logic [CH_W-1:0] LFSR_TAPS = CH_W'(LFSR_TAPS_DEF),
    parameter int              VOTES     = 5,
    parameter int              SETUP     = 2,
    parameter int              HOLD      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        num_crp,
    input  logic              seed_load,
    input  logic [CH_W-1:0]   seed,
    output logic              puf_launch,
    output logic [CH_W-1:0]   puf_challenge,
    input  logic [RESP_W-1:0] puf_response,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_challenge,
    output logic [RESP_W-1:0] out_response,
    output logic [RESP_W-1:0] out_unstable,
    output logic              busy,
    output logic              done
);

    localparam int VW    = clog2(VOTES + 1);
    localparam int CYC_W = clog2(((SETUP > HOLD) ? SETUP : HOLD) + 1);

    state_e           state_q;
    logic [CH_W-1:0]  lfsr_q, lfsr_d;
    logic [CYC_W-1:0] cyc_q;
    logic [VW-1:0]    fires_q;
    logic [8:0]       rem_q;
    logic             handshake, fire_last, vc_sample, vc_clear;
    logic [RESP_W-1:0] maj, unst;

    assign lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign handshake = out_valid && out_ready;
    assign fire_last = (state_q == ST_FIRE) && (cyc_q == CYC_W'(HOLD - 1));
    assign vc_sample = fire_last && !abort;
    assign vc_clear  = ((state_q == ST_IDLE) && start && !seed_load) ||
                       ((state_q == ST_EMIT) && handshake && !abort);
    assign busy      = state_q != ST_IDLE;

    for (genvar g = 0; g < RESP_W; g++) begin : g_vote
        puf_vote_counter #(.VOTES(VOTES)) u_vote (
            .clk       (clk),
            .rst       (rst),
            .resp_i    (puf_response[g]),
            .sample_i  (vc_sample),
            .clear_i   (vc_clear),
            .maj_o     (maj[g]),
            .unstable_o(unst[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= CH_W'(1);
            cyc_q         <= '0;
            fires_q       <= '0;
            rem_q         <= '0;
            puf_launch    <= 1'b0;
            puf_challenge <= '0;
            out_valid     <= 1'b0;
            out_challenge <= '0;
            out_response  <= '0;
            out_unstable  <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q != ST_IDLE && abort) begin
                state_q    <= ST_IDLE;
                puf_launch <= 1'b0;
                out_valid  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (seed_load) begin
                            lfsr_q <= (seed == '0) ? CH_W'(1) : seed;
                        end else if (start) begin
                            state_q       <= ST_ARM;
                            rem_q         <= (num_crp == 8'd0) ? 9'd256 : {1'b0, num_crp};
                            puf_challenge <= lfsr_q;
                            cyc_q         <= '0;
                            fires_q       <= '0;
                        end
                    end
                    ST_ARM: begin
                        puf_launch <= 1'b0;
                        if (cyc_q == CYC_W'(SETUP - 1)) begin
                            state_q    <= ST_FIRE;
                            cyc_q      <= '0;
                            puf_launch <= 1'b1;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        if (fire_last) begin
                            puf_launch <= 1'b0;
                            cyc_q      <= '0;
                            fires_q    <= fires_q + 1'b1;
                            state_q    <= (fires_q == VW'(VOTES - 1)) ? ST_EMIT : ST_ARM;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    default: begin
                        // First EMIT cycle registers the vote result; valid rises the cycle after.
                        if (!out_valid) begin
                            out_valid     <= 1'b1;
                            out_challenge <= puf_challenge;
                            out_response  <= maj;
                            out_unstable  <= unst;
                        end else if (out_ready) begin
                            out_valid     <= 1'b0;
                            lfsr_q        <= lfsr_d;
                            puf_challenge <= lfsr_d;
                            rem_q         <= rem_q - 1'b1;
                            fires_q       <= '0;
                            cyc_q         <= '0;
                            state_q       <= (rem_q == 9'd1) ? ST_IDLE : ST_ARM;
                            done          <= rem_q == 9'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
Upstream/downstream controller for the 8-bit arbiter-PUF array.
- Generates challenges from an LFSR and drives the array's launch pulse and challenge bus.
- Fires each challenge VOTES times, synchronises and majority-votes the response bits, then emits challenge/response pairs (CRPs) over a valid/ready handshake.
- Sits between the tile's host-side pins and the arbiter-PUF array.

Parameters:
CH_W, 8, challenge width; must equal the PUF mux-chain length.
RESP_W, 8, response width (one bit per PUF instance).
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask.
VOTES, 5, evaluations per challenge; must be odd and ≥1.
SETUP, 2, cycles with launch low and challenge stable before each fire; must be ≥1.
HOLD, 4, cycles with launch high per fire; must be ≥3 to cover the 2-flop synchroniser.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  synchronous abort; returns to IDLE.
num_crp  in  8  CRPs per run; 0 means 256.
seed_load  in  1  load seed into LFSR; honoured only in IDLE.
seed  in  CH_W  LFSR seed; 0 is replaced by 1.
puf_launch  out  1  drives PUF ipulse.
puf_challenge  out  CH_W  drives PUF ichallenge.
puf_response  in  RESP_W  PUF oresponse; asynchronous to clk.
out_valid  out  1  CRP available.
out_ready  in  1  consumer accepts.
out_challenge  out  CH_W  challenge of the emitted CRP.
out_response  out  RESP_W  majority-voted response.
out_unstable  out  RESP_W  per-bit flag: votes were not unanimous.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse after the last CRP handshake.

Behaviour:
- Reset values: all outputs 0; LFSR = 1; state IDLE.
- States: IDLE, ARM, FIRE, EMIT.
- IDLE:
  - seed_load has priority over start in the same cycle.
  - start (with no seed_load) → ARM; latch num_crp; clear vote counters.
- ARM: puf_launch=0; puf_challenge=LFSR; lasts SETUP cycles → FIRE.
- FIRE:
  - puf_launch=1 for HOLD cycles.
  - puf_response passes through a 2-flop synchroniser per bit.
  - On the last FIRE cycle, each vote counter (width clog2(VOTES+1)) increments where the synchronised bit = 1.
  - Next state: ARM if fewer than VOTES fires are done, else EMIT.
- EMIT:
  - out_valid=1; out_response[b] = (count[b] > VOTES/2).
  - out_unstable[b] = (count[b] ≠ 0 && count[b] ≠ VOTES).
  - out_challenge = challenge used.
  - Outputs are held stable until out_ready.
  - On handshake: LFSR advances (next = (l>>1) ^ (l[0] ? LFSR_TAPS : 0)); remaining count decrements; counters clear.
  - If remaining > 0 → ARM; else → IDLE with done=1 for one cycle.
- Latency: out_valid rises VOTES*(SETUP+HOLD)+1 cycles after start is sampled (31 with defaults).
- The first CRP of a run uses the current LFSR value. The LFSR persists across runs unless reloaded.
- abort (any non-IDLE state) → IDLE next cycle:
  - puf_launch and out_valid drop; done not pulsed.
  - LFSR not advanced; the in-flight CRP is discarded.
  - abort beats a simultaneous handshake.
- start is ignored while busy.
- rst mid-fire: puf_launch drops asynchronously.

Optional Feature:
PUF_UNSTABLE_FLAG_EN:
- Defined: out_unstable is computed as above.
- Undefined: out_unstable is tied to 0 and the unanimity logic is removed. The port remains present in both builds.

Decomposition:
- Package puf_pkg holds:
  - the state enum;
  - the CH_W/RESP_W defaults;
  - the LFSR_TAPS default;
  - a clog2 constant function for counter width.
- One sub-module, puf_vote_counter: one instance per response bit, containing the synchroniser, counter, majority and unanimity logic.

Test Plan:
- Reset, then seed_load seed=8'h00 → LFSR=8'h01; all outputs 0, busy=0.
- Seed 8'h01, num_crp=4, PUF model holds 8'hA5 → out_challenge 01, B8, 5C, 2E; out_response A5 each; out_unstable 00; out_valid at cycle 31; done pulses once after the 4th handshake.
- PUF model alternates A5/5A per fire (A5 first) → out_response A5; out_unstable FF (only FF when the feature macro is defined; else 00).
- out_ready held low for 10 cycles in EMIT → out_valid and all data stable for the full stall; the LFSR does not advance until the handshake.
- abort during the 3rd FIRE → IDLE next cycle; puf_launch=0; no done pulse. A following start reuses the same challenge.
- num_crp=0 → exactly 256 CRPs; the challenge after 255 handshakes wraps to the seed.
